// File: rtl/mem_io_responder.sv
// mem_io_responder: processor bus responder with RAM, LED register, switch port and prescaled down-counter timer
module mem_io_responder #(
  parameter int    RAM_BITS  = 8,
  parameter string INIT_FILE = "",
  parameter int    PRESCALE  = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic [9:0]  SW,
  output logic [15:0] DIN,
  output logic [9:0]  LEDR,
  output logic        TMR_IRQ
);
  logic [15:0] ram [2**RAM_BITS];
  logic [9:0]  sw_s1, sw_s2;
  logic [15:0] load, count, tmr_rd, rd_data;
  logic [31:0] pre;
  logic        run, auto, expired;
  logic [3:0]  region;
  logic        ld_wr, ctrl_wr, st_wr, tick, expire;
  logic        unused_addr;
  assign unused_addr = ^ADDR;
  assign region  = ADDR[15:12];
  assign ld_wr   = W && region == 4'h4 && ADDR[1:0] == 2'd0;
  assign ctrl_wr = W && region == 4'h4 && ADDR[1:0] == 2'd1;
  assign st_wr   = W && region == 4'h4 && ADDR[1:0] == 2'd3;
  assign tick    = run && pre == 32'(PRESCALE - 1);
  assign expire  = tick && count == 16'd0 && !ld_wr;
  assign TMR_IRQ = expired;
  always_comb begin
    tmr_rd  = ADDR[1:0] == 2'd0 ? load :
              ADDR[1:0] == 2'd1 ? {14'b0, auto, run} :
              ADDR[1:0] == 2'd2 ? count : {15'b0, expired};
    rd_data = region == 4'h0 ? ram[ADDR[RAM_BITS-1:0]] :
              region == 4'h1 ? {6'b0, LEDR} :
              region == 4'h3 ? {6'b0, sw_s2} :
              region == 4'h4 ? tmr_rd : 16'h0000;
  end
  always_ff @(posedge Clock)
    if (W && region == 4'h0) ram[ADDR[RAM_BITS-1:0]] <= DOUT;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      DIN     <= '0;
      LEDR    <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      load    <= '0;
      count   <= '0;
      pre     <= '0;
      run     <= 1'b0;
      auto    <= 1'b0;
      expired <= 1'b0;
    end else begin
      DIN   <= rd_data;
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      if (W && region == 4'h1) LEDR <= DOUT[9:0];
      if (ld_wr) begin
        load  <= DOUT;
        count <= DOUT;
        pre   <= '0;
      end else if (run) begin
        pre <= tick ? '0 : pre + 32'd1;
        if (tick) count <= count != 16'd0 ? count - 16'd1 : auto ? load : count;
      end
      if (ctrl_wr) begin
        run  <= DOUT[0];
        auto <= DOUT[1];
      end else if (expire && !auto) run <= 1'b0;
      if (expire) expired <= 1'b1;
      else if (st_wr) expired <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: randomized and directed checks of mem_io_responder against a behavioural model
module tb_mem_io_responder;
  logic        Clock = 0, Resetn = 0, W = 0;
  logic [15:0] ADDR = 0, DOUT = 0;
  logic [9:0]  SW = 0;
  logic [15:0] DIN;
  logic [9:0]  LEDR;
  logic        TMR_IRQ;
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [9:0]  m_led, sw_h0, sw_h1;
  int          m_load, m_count, m_pre;
  bit          m_run, m_auto, m_exp;
  mem_io_responder #(.RAM_BITS(8), .INIT_FILE(""), .PRESCALE(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W), .SW(SW),
    .DIN(DIN), .LEDR(LEDR), .TMR_IRQ(TMR_IRQ)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic m_reset();
    m_led = 0; sw_h0 = 0; sw_h1 = 0;
    m_load = 0; m_count = 0; m_pre = 0;
    m_run = 0; m_auto = 0; m_exp = 0;
  endtask
  task automatic m_read(input logic [15:0] a, output logic [15:0] v, output bit known);
    known = 1;
    v = 0;
    if (a[15:12] == 0) begin
      known = m_known[a[7:0]];
      v = m_ram[a[7:0]];
    end else if (a[15:12] == 1) v = 16'(m_led);
    else if (a[15:12] == 3) v = 16'(sw_h1);
    else if (a[15:12] == 4)
      v = a[1:0] == 0 ? 16'(m_load) : a[1:0] == 1 ? 16'({m_auto, m_run}) :
          a[1:0] == 2 ? 16'(m_count) : 16'(m_exp);
  endtask
  task automatic m_step(input logic [15:0] a, input logic [15:0] d, input logic w);
    bit tmr = a[15:12] == 4;
    sw_h1 = sw_h0;
    sw_h0 = SW;
    if (w && a[15:12] == 0) begin
      m_ram[a[7:0]] = d;
      m_known[a[7:0]] = 1;
    end
    if (w && a[15:12] == 1) m_led = d[9:0];
    if (w && tmr && a[1:0] == 3) m_exp = 0;
    if (w && tmr && a[1:0] == 0) begin
      m_load = d; m_count = d; m_pre = 0;
    end else if (m_run) begin
      if (m_pre == 3) begin
        m_pre = 0;
        if (m_count > 0) m_count--;
        else begin
          m_exp = 1;
          if (m_auto) m_count = m_load;
          else m_run = 0;
        end
      end else m_pre++;
    end
    if (w && tmr && a[1:0] == 1) begin
      m_run = d[0]; m_auto = d[1];
    end
  endtask
  task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic w);
    logic [15:0] e;
    bit k;
    ADDR = a; DOUT = d; W = w;
    m_read(a, e, k);
    @(posedge Clock);
    m_step(a, d, w);
    #1;
    if (k) chk("din", DIN, e);
    chk("ledr", {6'b0, LEDR}, {6'b0, m_led});
    chk("irq", {15'b0, TMR_IRQ}, {15'b0, m_exp});
  endtask
  initial begin
    bit found;
    m_reset();
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_din", DIN, 16'h0);
    chk("rst_led", {6'b0, LEDR}, 16'h0);
    chk("rst_irq", {15'b0, TMR_IRQ}, 16'h0);
    Resetn = 1;
    cycle(16'h0003, 16'h00A5, 1);
    cycle(16'h0003, 0, 0);
    cycle(16'h0103, 0, 0);
    chk("t1_alias", DIN, 16'h00A5);
    cycle(16'h0010, 16'h1111, 1);
    cycle(16'h0010, 16'h1234, 1);
    chk("t2_old", DIN, 16'h1111);
    cycle(16'h0010, 0, 0);
    chk("t2_new", DIN, 16'h1234);
    cycle(16'h1000, 16'h03FF, 1);
    chk("t3_led", {6'b0, LEDR}, 16'h03FF);
    cycle(16'h1000, 0, 0);
    chk("t3_ledrd", DIN, 16'h03FF);
    SW = 10'h155;
    repeat (3) cycle(16'h3000, 16'hFFFF, 1);
    chk("t3_sw", DIN, 16'h0155);
    cycle(16'h4000, 2, 1);
    cycle(16'h4001, 1, 1);
    repeat (20) cycle(16'h4002, 0, 0);
    chk("t4_count", DIN, 16'h0);
    chk("t4_irq", {15'b0, TMR_IRQ}, 16'h1);
    cycle(16'h4001, 0, 0);
    chk("t4_ctrl", DIN, 16'h0);
    cycle(16'h4000, 1, 1);
    cycle(16'h4001, 3, 1);
    repeat (16) cycle(16'h4002, 0, 0);
    chk("t5_irq", {15'b0, TMR_IRQ}, 16'h1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++)
      if (m_run && m_pre == 3) cycle(16'h4002, 0, 0); else found = 1;
    chk("t5_find_clear", 16'(found), 16'h1);
    cycle(16'h4003, 16'hFFFF, 1);
    chk("t5_cleared", {15'b0, TMR_IRQ}, 16'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++)
      if (m_run && m_pre == 3 && m_count == 0) found = 1; else cycle(16'h4002, 0, 0);
    chk("t5_find_expiry", 16'(found), 16'h1);
    cycle(16'h4003, 0, 1);
    chk("t5_expiry_wins", {15'b0, TMR_IRQ}, 16'h1);
    cycle(16'h8000, 16'h5A5A, 1);
    cycle(16'h8000, 0, 0);
    chk("t6_other", DIN, 16'h0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [15:0] d;
      int r = $urandom_range(0, 9);
      a = r < 3 ? {4'h0, 4'($urandom), 8'($urandom_range(0, 7))} :
          r == 3 ? 16'h1000 : r == 4 ? 16'h3000 : r == 5 ? 16'h8123 :
          {14'h1000, 2'($urandom)};
      d = a == 16'h4000 ? 16'($urandom_range(0, 4)) :
          a == 16'h4001 ? 16'($urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      cycle(a, d, $urandom_range(0, 3) == 0);
    end
    cycle(16'h4000, 16'd100, 1);
    cycle(16'h4001, 1, 1);
    cycle(16'h1000, 16'h02AA, 1);
    repeat (5) cycle(16'h4002, 0, 0);
    Resetn = 0;
    #1;
    m_reset();
    chk("t6_rst_din", DIN, 16'h0);
    chk("t6_rst_led", {6'b0, LEDR}, 16'h0);
    chk("t6_rst_irq", {15'b0, TMR_IRQ}, 16'h0);
    @(negedge Clock);
    Resetn = 1;
    SW = 0;
    cycle(16'h4002, 0, 0);
    chk("t6_count", DIN, 16'h0);
    cycle(16'h4001, 0, 0);
    chk("t6_ctrl", DIN, 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
